// File: rtl/any1_pkg.sv
// Shared types and constants for the ANY-1 system bus arbiter.
package any1_pkg;

    // Arbiter tenure states: waiting for requests, or a master owns the bus.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    // Default watchdog limit in clocks for a hung bus cycle.
    localparam int unsigned ANY1_TOCNT_DEF = 32'd64;

    // Width of a counter that must be able to hold the value tocnt itself.
    function automatic int unsigned tocnt_width(input int unsigned tocnt);
        return $clog2(tocnt + 32'd1);
    endfunction

    // Width of a master index; at least one bit even for a single master.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/any1_rr_pick.sv
// Combinational round-robin picker: starting at last+1 (mod NM), the first
// requesting master wins. Produces a one-hot grant, its index and a valid flag.
module any1_rr_pick
    import any1_pkg::*;
#(
    parameter int unsigned NM = 2,
    parameter int unsigned LW = 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [LW-1:0] last_i,
    output logic [NM-1:0] gnt_o,
    output logic [LW-1:0] idx_o,
    output logic          valid_o
);

    logic [LW-1:0] k_s;
    logic          hit_s;

    // Scan masters in priority order last+1, last+2, ...; first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k_s     = '0;
        hit_s   = 1'b0;
        for (int unsigned i = 32'd1; i <= NM; i++) begin
            k_s        = LW'((32'(last_i) + i) % NM);
            hit_s      = ~valid_o & req_i[k_s];
            gnt_o[k_s] = gnt_o[k_s] | hit_s;
            idx_o      = hit_s ? k_s : idx_o;
            valid_o    = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/any1_bus_arb.sv
// Round-robin Wishbone arbiter for the ANY-1 128-bit system bus.
// A granted master keeps the bus for its whole cyc tenure; slave-side
// controls are registered copies of the owner's signals, and stb drops for
// one cycle after every ack/err so a beat is never acknowledged twice.
// Optional feature: define ANY1_BUSARB_TIMEOUT_EN to enable a watchdog that
// errors out a strobe left unanswered for TOCNT clocks.
module any1_bus_arb
    import any1_pkg::*;
#(
    parameter int unsigned NM    = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 128,
    parameter int unsigned TOCNT = ANY1_TOCNT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        gnt_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DW/8-1:0]      sel_o,
    output logic [AW-1:0]        adr_o,
    output logic [DW-1:0]        dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic [DW-1:0]        dat_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned LW = idx_width(NM);

    arb_state_e    state_q, state_d;
    logic [NM-1:0] gnt_q,   gnt_d;
    logic [LW-1:0] gidx_q,  gidx_d;
    logic [LW-1:0] last_q,  last_d;
    logic          cyc_q,   cyc_d;
    logic          stb_q,   stb_d;
    logic          we_q,    we_d;
    logic [SW-1:0] sel_q,   sel_d;
    logic [AW-1:0] adr_q,   adr_d;
    logic [DW-1:0] dat_q,   dat_d;

    logic [NM-1:0] pick_gnt_s;
    logic [LW-1:0] pick_idx_s;
    logic          pick_valid_s;

    logic          g_cyc_s;
    logic          g_stb_s;
    logic          g_we_s;
    logic [SW-1:0] g_sel_s;
    logic [AW-1:0] g_adr_s;
    logic [DW-1:0] g_dat_s;

    logic          timeout_s;

    any1_rr_pick #(
        .NM (NM),
        .LW (LW)
    ) u_pick (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // AND-OR multiplexer selecting the current owner's bus signals.
    always_comb begin
        g_cyc_s = 1'b0;
        g_stb_s = 1'b0;
        g_we_s  = 1'b0;
        g_sel_s = '0;
        g_adr_s = '0;
        g_dat_s = '0;
        for (int unsigned k = 32'd0; k < NM; k++) begin
            g_cyc_s = g_cyc_s | (m_cyc_i[k] & (gidx_q == LW'(k)));
            g_stb_s = g_stb_s | (m_stb_i[k] & (gidx_q == LW'(k)));
            g_we_s  = g_we_s  | (m_we_i[k]  & (gidx_q == LW'(k)));
            g_sel_s = g_sel_s | (m_sel_i[k*SW +: SW] & {SW{gidx_q == LW'(k)}});
            g_adr_s = g_adr_s | (m_adr_i[k*AW +: AW] & {AW{gidx_q == LW'(k)}});
            g_dat_s = g_dat_s | (m_dat_i[k*DW +: DW] & {DW{gidx_q == LW'(k)}});
        end
    end

`ifdef ANY1_BUSARB_TIMEOUT_EN
    localparam int unsigned CW = tocnt_width(TOCNT);

    logic [CW-1:0] tocnt_q, tocnt_d;

    // Watchdog fires when a strobe has waited TOCNT clocks with no response.
    assign timeout_s = stb_q & ~ack_i & ~err_i & (tocnt_q == CW'(TOCNT));

    // Count unanswered strobe cycles; any response, idle strobe or firing clears.
    always_comb begin
        tocnt_d = '0;
        if (stb_q & ~ack_i & ~err_i & ~timeout_s) begin
            tocnt_d = tocnt_q + CW'(1'b1);
        end else begin
            tocnt_d = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tocnt_q <= '0;
        end else begin
            tocnt_q <= tocnt_d;
        end
    end
`else
    logic unused_tocnt_s;

    assign timeout_s      = 1'b0;
    assign unused_tocnt_s = (TOCNT == 32'd0);
`endif

    // Next-state and registered bus copies for the IDLE/OWN tenure FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ARB_OWN;
                    gnt_d   = pick_gnt_s;
                    gidx_d  = pick_idx_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWN: begin
                we_d  = g_we_s;
                sel_d = g_sel_s;
                adr_d = g_adr_s;
                dat_d = g_dat_s;
                if (g_cyc_s) begin
                    cyc_d = 1'b1;
                    stb_d = g_stb_s & ~(ack_i | err_i) & ~timeout_s;
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant and slave-side output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= LW'(NM - 32'd1);
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = stb_q;
    assign we_o    = we_q;
    assign sel_o   = sel_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign m_ack_o = gnt_q & {NM{ack_i}};
    assign m_err_o = gnt_q & {NM{err_i | timeout_s}};
    assign m_dat_o = dat_i;

endmodule

// File: tb/tb_any1_bus_arb.sv
// Self-checking bench for any1_bus_arb (NM=2, TOCNT=16). Expected slave-side
// transfers are queued per master when a request is driven and checked when
// the arbiter presents the strobe; expected read data is queued when the
// slave answers and checked on the master side.
module tb_any1_bus_arb;

    localparam int NM    = 2;
    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int SW    = DW / 8;
    localparam int TOCNT = 16;

    typedef struct {
        logic          we;
        logic [SW-1:0] sel;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } req_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [NM*SW-1:0]  m_sel_i;
    logic [NM*AW-1:0]  m_adr_i;
    logic [NM*DW-1:0]  m_dat_i;
    logic [NM-1:0]     m_ack_o, m_err_o, gnt_o;
    logic [DW-1:0]     m_dat_o, dat_o, dat_i;
    logic              cyc_o, stb_o, we_o, ack_i, err_i;
    logic [SW-1:0]     sel_o;
    logic [AW-1:0]     adr_o;

    req_t          sb0[$];
    req_t          sb1[$];
    logic [DW-1:0] rd_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;

    always #5 clk_i = ~clk_i;

    any1_bus_arb #(.NM(NM), .AW(AW), .DW(DW), .TOCNT(TOCNT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .gnt_o(gnt_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv_req(input int m, input logic we, input logic [SW-1:0] sel,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        req_t r;
        m_cyc_i[m] = 1'b1;
        m_stb_i[m] = 1'b1;
        m_we_i[m]  = we;
        m_sel_i[m*SW +: SW] = sel;
        m_adr_i[m*AW +: AW] = adr;
        m_dat_i[m*DW +: DW] = dat;
        r = '{we, sel, adr, dat};
        if (m == 0) sb0.push_back(r);
        else        sb1.push_back(r);
    endtask

    task automatic drop(input int m);
        m_cyc_i[m] = 1'b0;
        m_stb_i[m] = 1'b0;
    endtask

    task automatic sb_check(input int m);
        req_t          r;
        logic [NM-1:0] eg;
        int            avail;
        eg = '0;
        eg[m] = 1'b1;
        avail = (m == 0) ? sb0.size() : sb1.size();
        chk("sb_stb", stb_o, 1'b1);
        chk("sb_gnt", gnt_o, eg);
        chk("sb_avail", (avail > 0), 1'b1);
        if (avail > 0) begin
            r = (m == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("sb_adr", adr_o, r.adr);
            chk("sb_sel", sel_o, r.sel);
            chk("sb_we",  we_o,  r.we);
            if (r.we) chk("sb_dat", dat_o, r.dat);
        end
    endtask

    task automatic resp(input int m, input logic a, input logic e, input logic [DW-1:0] d);
        logic [NM-1:0] ea, ee;
        ea = '0;
        ee = '0;
        ea[m] = a;
        ee[m] = e;
        ack_i = a;
        err_i = e;
        dat_i = d;
        if (a) rd_q.push_back(d);
        #1;
        chk("resp_ack", m_ack_o, ea);
        chk("resp_err", m_err_o, ee);
        if (a && rd_q.size() > 0) chk("resp_rdata", m_dat_o, rd_q.pop_front());
    endtask

    task automatic resp_clear();
        ack_i = 1'b0;
        err_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        resp_clear();
        sb0.delete();
        sb1.delete();
        rd_q.delete();
        tick();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_stb", stb_o, 1'b0);
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb watchdog");
    end

    initial begin
        m_we_i  = '0;
        m_sel_i = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        dat_i   = '0;
        do_reset();

        // A: single read by master 0 and its latency.
        drv_req(0, 1'b0, 16'h000F, 32'hFFDC1100, 128'h0);
        tick();
        chk("A_gnt", gnt_o, 2'b01);
        chk("A_cyc_early", cyc_o, 1'b0);
        tick();
        chk("A_cyc", cyc_o, 1'b1);
        sb_check(0);
        resp(0, 1'b1, 1'b0, 128'h0123456789ABCDEF00000000DEADBEEF);
        tick();
        chk("A_stb_dead", stb_o, 1'b0);
        chk("A_cyc_hold", cyc_o, 1'b1);
        resp_clear();
        drop(0);
        tick();
        chk("A_cyc_rel", cyc_o, 1'b0);
        chk("A_gnt_rel", gnt_o, 2'b00);

        // B: both request after reset, then alternation.
        do_reset();
        drv_req(0, 1'b1, 16'hFFFF, 32'h00001000, 128'hA0A0);
        drv_req(1, 1'b1, 16'h00FF, 32'h00002000, 128'hB1B1);
        tick();
        chk("B_gnt_m0", gnt_o, 2'b01);
        tick();
        sb_check(0);
        resp(0, 1'b1, 1'b0, 128'h0);
        tick();
        resp_clear();
        drop(0);
        tick();
        chk("B_rel", gnt_o, 2'b00);
        tick();
        chk("B_gnt_m1", gnt_o, 2'b10);
        tick();
        sb_check(1);
        resp(1, 1'b1, 1'b0, 128'h0);
        tick();
        resp_clear();
        drop(1);
        tick();
        chk("B_rel2", gnt_o, 2'b00);
        drv_req(0, 1'b0, 16'h0001, 32'h00003000, 128'h0);
        drv_req(1, 1'b0, 16'h0002, 32'h00004000, 128'h0);
        tick();
        chk("B_alt", gnt_o, 2'b01);

        // C: 4-beat burst by master 0 while master 1 waits.
        do_reset();
        drv_req(0, 1'b0, 16'hFFFF, 32'h00005000, 128'h0);
        drv_req(1, 1'b0, 16'hFFFF, 32'h00006000, 128'h0);
        tick();
        tick();
        for (int b = 0; b < 4; b++) begin
            sb_check(0);
            resp(0, 1'b1, 1'b0, {96'h0, 32'hC0DE0000 + b});
            tick();
            chk("C_dead", stb_o, 1'b0);
            chk("C_gnt", gnt_o, 2'b01);
            resp_clear();
            if (b < 3) drv_req(0, 1'b0, 16'hFFFF, 32'h00005000 + 32'((b + 1) * 16), 128'h0);
            else       drop(0);
            tick();
        end
        chk("C_rel", gnt_o, 2'b00);
        tick();
        chk("C_gnt_m1", gnt_o, 2'b10);

        // D: unanswered strobe (watchdog behaviour depends on build).
        do_reset();
        drv_req(0, 1'b0, 16'h00F0, 32'h00007000, 128'h0);
        tick();
        tick();
        sb_check(0);
        repeat (15) tick();
        chk("D_no_err_early", m_err_o, 2'b00);
        tick();
`ifdef ANY1_BUSARB_TIMEOUT_EN
        chk("D_to_err", m_err_o, 2'b01);
        chk("D_to_stb_hi", stb_o, 1'b1);
        tick();
        chk("D_to_stb_lo", stb_o, 1'b0);
        chk("D_to_pulse", m_err_o, 2'b00);
`else
        chk("D_no_err", m_err_o, 2'b00);
        repeat (20) tick();
        chk("D_hold", stb_o, 1'b1);
        chk("D_no_err_late", m_err_o, 2'b00);
`endif

        // E: err during master 1 tenure; responses ignored without grant.
        do_reset();
        drv_req(1, 1'b1, 16'h0F00, 32'h00008000, 128'h5555);
        tick();
        chk("E_gnt", gnt_o, 2'b10);
        tick();
        sb_check(1);
        resp(1, 1'b0, 1'b1, 128'h0);
        tick();
        resp_clear();
        drop(1);
        tick();
        chk("E_rel", gnt_o, 2'b00);
        ack_i = 1'b1;
        err_i = 1'b1;
        #1;
        chk("E_ign_ack", m_ack_o, 2'b00);
        chk("E_ign_err", m_err_o, 2'b00);
        resp_clear();

        // F: asynchronous reset in the middle of a tenure.
        drv_req(0, 1'b0, 16'hFFFF, 32'h00009000, 128'h0);
        tick();
        tick();
        sb_check(0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("F_gnt", gnt_o, 2'b00);
        chk("F_cyc", cyc_o, 1'b0);
        chk("F_stb", stb_o, 1'b0);
        #1;
        rst_i = 1'b0;
        drv_req(1, 1'b0, 16'hFFFF, 32'h0000A000, 128'h0);
        tick();
        chk("F_first", gnt_o, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
